imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Definitions shared by the instruction-memory loader: word/byte geometry,
// the loader FSM state encoding and the big-endian lane extraction helper.
package imem_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int BYTE_SIZE  = 8;
  localparam int NUM_LANES  = 4;
  localparam int LANE_WIDTH = $clog2(NUM_LANES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    WRITE,
    DONE,
    ERR
  } state_t;

  // Lane 0 is the most significant byte (big-endian byte order in memory).
  function automatic logic [BYTE_SIZE-1:0] lane_byte(
    input logic [WORD_SIZE-1:0]  word,
    input logic [LANE_WIDTH-1:0] lane
  );
    return word[WORD_SIZE-1 - BYTE_SIZE*int'(lane) -: BYTE_SIZE];
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// one byte per cycle, big-endian, with alignment and overflow protection.
module imem_loader
  import imem_pkg::*;
#(
  parameter  int MEM_SIZE   = 1024,
  localparam int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_SIZE-1:0]  start_addr,
  input  logic [WORD_SIZE-1:0]  word_in,
  input  logic                  word_valid,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BYTE_SIZE-1:0]  mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_written
);

  // One spare bit lets the counter step past the top of memory instead of
  // wrapping, so the overflow check below sees the true address.
  localparam int                  CNT_WIDTH = ADDR_WIDTH + 1;
  localparam int                  END_WIDTH = ADDR_WIDTH + 2;
  localparam logic [END_WIDTH-1:0] MEM_LIMIT = END_WIDTH'(MEM_SIZE);
  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(NUM_LANES - 1);

  state_t                  state, state_next;
  logic [CNT_WIDTH-1:0]    addr;
  logic [END_WIDTH-1:0]    addr_end;
  logic [LANE_WIDTH-1:0]   lane, lane_next;
  logic [WORD_SIZE-1:0]    word_q;
  logic                    last_q;
  logic                    accept;
  logic                    start_unused;

  assign start_unused = ^start_addr[WORD_SIZE-1:ADDR_WIDTH];
  assign accept       = word_valid && word_ready;
  assign addr_end     = {1'b0, addr} + END_WIDTH'(NUM_LANES - 1);
  assign lane_next    = lane + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (start) state_next = (start_addr[1:0] != 2'b00) ? ERR : WAIT_WORD;
      WAIT_WORD: if (accept) state_next = (addr_end >= MEM_LIMIT) ? ERR : WRITE;
      WRITE:     if (lane == LAST_LANE) state_next = last_q ? DONE : WAIT_WORD;
      DONE:      state_next = IDLE;
      ERR:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // NOTE: every output is a flop loaded from state_next, so it changes on the
  // same edge as the state it describes and never glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_ready    <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
      addr          <= '0;
      lane          <= '0;
      word_q        <= '0;
      last_q        <= 1'b0;
    end else begin
      word_ready <= (state_next == WAIT_WORD);
      mem_we     <= (state_next == WRITE);
      busy       <= (state_next != IDLE);
      done       <= (state_next == DONE);

      if (state_next == ERR)          error <= 1'b1;
      else if (state == IDLE && start) error <= 1'b0;

      if (state == IDLE && start) begin
        words_written <= '0;
        addr          <= {1'b0, start_addr[ADDR_WIDTH-1:0]};
      end

      // Byte 0 goes out on the acceptance edge; the rest follow one per cycle.
      if (state == WAIT_WORD && state_next == WRITE) begin
        word_q    <= word_in;
        last_q    <= word_last;
        lane      <= '0;
        mem_addr  <= addr[ADDR_WIDTH-1:0];
        mem_wdata <= lane_byte(word_in, '0);
      end

      if (state == WRITE) begin
        if (lane == LAST_LANE) begin
          addr          <= addr + CNT_WIDTH'(NUM_LANES);
          words_written <= words_written + 1'b1;
        end else begin
          lane      <= lane_next;
          mem_addr  <= addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(lane_next);
          mem_wdata <= lane_byte(word_q, lane_next);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, single and streamed words,
// misaligned start, end-of-memory overflow and reset abort mid-write.
module tb_imem_loader;

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] start_addr;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_last;
  logic        word_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  words_written;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          rdy_cnt  = 0;
  wr_t         wq[$];
  logic [31:0] wbuf[4];

  imem_loader #(.MEM_SIZE(1024)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_addr    (start_addr),
    .word_in       (word_in),
    .word_valid    (word_valid),
    .word_last     (word_last),
    .word_ready    (word_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) wq.push_back('{cyc: cyc, addr: mem_addr, data: mem_wdata});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (word_ready) rdy_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    wq.delete();
    done_cnt = 0;
    done_cyc = -1;
    rdy_cnt  = 0;
  endtask

  task automatic start_session(input logic [31:0] a);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  // Holds word_valid high and advances to the next buffered word after each acceptance.
  task automatic send(input int n);
    int  i     = 0;
    int  guard = 0;
    logic acc;
    word_valid = 1'b1;
    word_in    = wbuf[0];
    word_last  = (n == 1);
    while (i < n && guard < 200) begin
      @(negedge clk);
      acc = word_ready && word_valid;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        i++;
        if (i < n) begin
          word_in   = wbuf[i];
          word_last = (i == n - 1);
        end
      end
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
    check("send_all_accepted", 32'(i), 32'(n));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  // Compares logged writes against big-endian expansion of wbuf from base address.
  task automatic check_writes(input string tag, input int nwords, input logic [9:0] base);
    check({tag, "_count"}, 32'(wq.size()), 32'(4 * nwords));
    for (int k = 0; k < 4 * nwords; k++) begin
      if (k < wq.size()) begin
        check({tag, "_addr"}, 32'(wq[k].addr), 32'(base + 10'(k)));
        check({tag, "_data"}, 32'(wq[k].data), 32'((wbuf[k / 4] >> (24 - 8 * (k % 4))) & 32'hFF));
        check({tag, "_cyc"}, 32'(wq[k].cyc - wq[0].cyc), 32'(5 * (k / 4) + (k % 4)));
      end
    end
  endtask

  initial begin
    int   n;
    logic found;

    rst        = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    word_in    = '0;
    word_valid = 1'b0;
    word_last  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_we",     32'(mem_we),        32'd0);
    check("rst_word_ready", 32'(word_ready),    32'd0);
    check("rst_busy",       32'(busy),          32'd0);
    check("rst_done",       32'(done),          32'd0);
    check("rst_error",      32'(error),         32'd0);
    check("rst_words",      32'(words_written), 32'd0);
    check("rst_mem_addr",   32'(mem_addr),      32'd0);
    check("rst_mem_wdata",  32'(mem_wdata),     32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single word at address 0
    clear_log();
    wbuf[0] = 32'h8C010004;
    start_session(32'h0);
    send(1);
    wait_idle(n);
    check_writes("single", 1, 10'h000);
    check("single_done_cnt", 32'(done_cnt), 32'd1);
    if (wq.size() == 4) check("single_done_cyc", 32'(done_cyc), 32'(wq[3].cyc + 1));
    check("single_words", 32'(words_written), 32'd1);
    check("single_error", 32'(error), 32'd0);

    // Three words streamed back-to-back from 0x10
    clear_log();
    wbuf[0] = 32'h12345678;
    wbuf[1] = 32'hA5B6C7D8;
    wbuf[2] = 32'h0F1E2D3C;
    start_session(32'h10);
    send(3);
    wait_idle(n);
    check_writes("stream", 3, 10'h010);
    check("stream_ready_cnt", 32'(rdy_cnt), 32'd3);
    check("stream_done_cnt", 32'(done_cnt), 32'd1);
    check("stream_words", 32'(words_written), 32'd3);
    check("stream_addr_hold", 32'(mem_addr), 32'h01B);
    check("stream_wdata_hold", 32'(mem_wdata), 32'h3C);

    // Misaligned start address
    clear_log();
    start_session(32'h6);
    check("misalign_error_now", 32'(error), 32'd1);
    wait_idle(n);
    check("misalign_idle_fast", 32'(n <= 2), 32'd1);
    check("misalign_no_write", 32'(wq.size()), 32'd0);
    check("misalign_no_done", 32'(done_cnt), 32'd0);
    repeat (3) @(negedge clk);
    check("misalign_sticky", 32'(error), 32'd1);

    // End of memory: second word overflows
    clear_log();
    wbuf[0] = 32'h11223344;
    wbuf[1] = 32'h55667788;
    start_session(32'h3FC);
    check("ovf_error_cleared", 32'(error), 32'd0);
    send(2);
    wait_idle(n);
    check_writes("ovf", 1, 10'h3FC);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_no_done", 32'(done_cnt), 32'd0);
    check("ovf_words", 32'(words_written), 32'd1);

    // Reset while the second byte of a word is on the bus
    clear_log();
    start_session(32'h20);
    word_in    = 32'hDEADBEEF;
    word_last  = 1'b1;
    word_valid = 1'b1;
    found      = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_we && mem_addr == 10'h021) found = 1'b1;
    end
    check("abort_second_byte_seen", 32'(found), 32'd1);
    rst        = 1'b0;
    word_valid = 1'b0;
    @(negedge clk);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(word_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_write_count", 32'(wq.size()), 32'd2);
    if (wq.size() >= 2) check("abort_last_data", 32'(wq[1].data), 32'hAD);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
